// File: rtl/mem_pkg.sv
// Shared types and default sizing for the memory responder block.
package mem_pkg;

  localparam int unsigned DEF_DATAWIDTH = 32;
  localparam int unsigned DEF_ADDRWIDTH = 18;
  localparam int unsigned DEF_DEPTH     = 262144;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, combinational read.
// Words come up zero and are never cleared afterwards.
module mem_array #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned ADDRWIDTH = 18,
  parameter int unsigned DEPTH     = 262144
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic [DATAWIDTH-1:0] wdata,
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 in_range
);

  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRWIDTH:0] DEPTH_W = (ADDRWIDTH + 1)'(DEPTH);

  logic [DATAWIDTH-1:0] mem_q [DEPTH] = '{default: '0};
  logic [IDXW-1:0]      idx;

  assign idx      = addr[IDXW-1:0];
  // Range test uses the full address so high bits never alias onto low words.
  assign in_range = ({1'b0, addr} < DEPTH_W);
  assign rdata    = in_range ? mem_q[idx] : '0;

  always_ff @(posedge clock) begin
    if (we && in_range) begin
      mem_q[idx] <= wdata;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder with one outstanding request.
// Optional MEM_RESPONDER_STATS_EN adds saturating read/write completion counters.
// Handshake: a request transfers on a rising edge with req_valid && req_ready;
// a response transfers on a rising edge with rsp_valid && rsp_ready and holds until then.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DEF_DATAWIDTH,
  parameter int unsigned ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned LATENCY   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDRWIDTH-1:0] req_addr,
  input  logic [DATAWIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATAWIDTH-1:0] rsp_rdata,
  output logic                 rsp_err,
  output state_e               dbg_state
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]          stat_reads,
  output logic [31:0]          stat_writes
`endif
);

  localparam logic [3:0] WAIT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 write_q, write_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d;
  logic [DATAWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;

  logic                 cur_write;
  logic [ADDRWIDTH-1:0] cur_addr;
  logic [DATAWIDTH-1:0] cur_wdata;
  logic [DATAWIDTH-1:0] mem_rdata;
  logic                 mem_in_range;
  logic                 mem_we;
  logic                 enter_resp;

  mem_array #(
    .DATAWIDTH(DATAWIDTH),
    .ADDRWIDTH(ADDRWIDTH),
    .DEPTH    (DEPTH)
  ) u_mem_array (
    .clock   (clock),
    .we      (mem_we),
    .addr    (cur_addr),
    .wdata   (cur_wdata),
    .rdata   (mem_rdata),
    .in_range(mem_in_range)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    enter_resp  = 1'b0;
    // With LATENCY=1 the access happens on the accepting edge, before the latches hold it.
    cur_write   = (state_q == IDLE) ? req_write : write_q;
    cur_addr    = (state_q == IDLE) ? req_addr  : addr_q;
    cur_wdata   = (state_q == IDLE) ? req_wdata : wdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY > 1) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      rsp_err_d   = !mem_in_range;
      rsp_rdata_d = (cur_write || !mem_in_range) ? '0 : mem_rdata;
    end
    // A reset landing on the commit edge must not let the write through.
    mem_we = enter_resp && cur_write && !reset;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

`ifdef MEM_RESPONDER_STATS_EN
  logic [31:0] stat_reads_q, stat_reads_d;
  logic [31:0] stat_writes_q, stat_writes_d;

  // Only responses actually handed over count; dropped or errored ones do not.
  always_comb begin
    stat_reads_d  = stat_reads_q;
    stat_writes_d = stat_writes_q;
    if (state_q == RESP && rsp_ready && !rsp_err_q) begin
      if (write_q) begin
        if (stat_writes_q != '1) stat_writes_d = stat_writes_q + 32'd1;
      end else begin
        if (stat_reads_q != '1) stat_reads_d = stat_reads_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
    end else begin
      stat_reads_q  <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
    end
  end

  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (DEPTH=1024, LATENCY=4); stats checks under MEM_RESPONDER_STATS_EN.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 18;
  localparam int DEP = 1024;
  localparam int LAT = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  state_e        dbg_state;
`ifdef MEM_RESPONDER_STATS_EN
  logic [31:0]   stat_reads;
  logic [31:0]   stat_writes;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  mem_responder #(
    .DATAWIDTH(DW),
    .ADDRWIDTH(AW),
    .DEPTH    (DEP),
    .LATENCY  (LAT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .dbg_state(dbg_state)
`ifdef MEM_RESPONDER_STATS_EN
    ,
    .stat_reads (stat_reads),
    .stat_writes(stat_writes)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
  task automatic start_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic txn(input string tag, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [DW-1:0] exp_data,
                     input logic exp_err);
    int lat;
    start_req(w, a, d);
    wait_rsp(lat);
    check({tag, "_lat"}, 32'(lat), 32'(LAT));
    check({tag, "_data"}, rsp_rdata, exp_data);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    @(negedge clock);
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    txn("wr_10", 1'b1, 18'h00010, 32'hDEADBEEF, 32'h0, 1'b0);
    txn("rd_10", 1'b0, 18'h00010, 32'h0, 32'hDEADBEEF, 1'b0);
    txn("rd_123", 1'b0, 18'h00123, 32'h0, 32'h0, 1'b0);

    // Out-of-range write at 0x400 would alias onto word 0 if the range test were wrong.
    txn("wr_000", 1'b1, 18'h00000, 32'h11112222, 32'h0, 1'b0);
    txn("wr_400", 1'b1, 18'h00400, 32'h12345678, 32'h0, 1'b1);
    txn("rd_400", 1'b0, 18'h00400, 32'h0, 32'h0, 1'b1);
    txn("rd_000", 1'b0, 18'h00000, 32'h0, 32'h11112222, 1'b0);

    // Backpressure: response holds, new requests are ignored.
    rsp_ready = 1'b0;
    start_req(1'b0, 18'h00010, 32'h0);
    wait_rsp(lat);
    check("bp_lat", 32'(lat), 32'(LAT));
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", rsp_rdata, 32'hDEADBEEF);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 18'h00010;
      req_wdata = 32'h00000BAD;
      @(negedge clock);
    end
    req_valid = 1'b0;
    req_write = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clock);
    check("bp_rel_state", 32'(dbg_state), 32'(IDLE));
    check("bp_rel_valid", 32'(rsp_valid), 32'd0);
    txn("bp_rd_10", 1'b0, 18'h00010, 32'h0, 32'hDEADBEEF, 1'b0);

    // Reset during WAIT discards an uncommitted write.
    txn("wr_20", 1'b1, 18'h00020, 32'hCAFEF00D, 32'h0, 1'b0);
    start_req(1'b1, 18'h00020, 32'h55555555);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rw_state", 32'(dbg_state), 32'(IDLE));
    check("rw_req_ready", 32'(req_ready), 32'd1);
    check("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    txn("rw_rd_20", 1'b0, 18'h00020, 32'h0, 32'hCAFEF00D, 1'b0);

    // Reset during RESP drops the response but keeps the committed write.
    rsp_ready = 1'b0;
    start_req(1'b1, 18'h00030, 32'h77778888);
    wait_rsp(lat);
    check("rr_lat", 32'(lat), 32'(LAT));
    reset = 1'b1;
    @(negedge clock);
    check("rr_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rr_rdata", rsp_rdata, 32'd0);
    reset = 1'b0;
    rsp_ready = 1'b1;
    txn("rr_rd_30", 1'b0, 18'h00030, 32'h0, 32'h77778888, 1'b0);

    // Since the last reset: one read done above; add 3 writes, 1 read, 1 out-of-range read.
    txn("st_wr_40", 1'b1, 18'h00040, 32'h00000040, 32'h0, 1'b0);
    txn("st_wr_41", 1'b1, 18'h00041, 32'h00000041, 32'h0, 1'b0);
    txn("st_wr_42", 1'b1, 18'h00042, 32'h00000042, 32'h0, 1'b0);
    txn("st_rd_41", 1'b0, 18'h00041, 32'h0, 32'h00000041, 1'b0);
    txn("st_rd_500", 1'b0, 18'h00500, 32'h0, 32'h0, 1'b1);
`ifdef MEM_RESPONDER_STATS_EN
    check("stat_writes", stat_writes, 32'd3);
    check("stat_reads", stat_reads, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDRWIDTH, default 18, word-address width in bits.
REQ-003 SHALL have parameter DEPTH, default 262144, number of implemented words; DEPTH <= 2**ADDRWIDTH.
REQ-004 SHALL have parameter LATENCY, default 4, cycles from request acceptance to rsp_valid; legal range 1..15.
REQ-005 SHALL have port clock  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_valid  input  1  initiator presents a request.
REQ-008 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-009 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-010 SHALL have port req_addr  input  ADDRWIDTH  word address.
REQ-011 SHALL have port req_wdata  input  DATAWIDTH  write data.
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  initiator consumes the response.
REQ-014 SHALL have port rsp_rdata  output  DATAWIDTH  read data; 0 for writes and errors.
REQ-015 SHALL have port rsp_err  output  1  request address >= DEPTH.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-017 IDLE: req_ready=1; on req_valid, SHALL latch write, addr and wdata, then go to WAIT (LATENCY>1) or directly to RESP (LATENCY=1).
REQ-018 WAIT: req_ready=0; a 4-bit down-counter loaded with LATENCY-2 SHALL decrement each cycle and move to RESP on the cycle after it reads 0.
REQ-019 Read or write SHALL execute on the cycle of entry into RESP, so that rsp_valid rises exactly LATENCY cycles after the accepting edge.
REQ-020 Write SHALL commit to storage only if addr < DEPTH; out-of-range writes SHALL be dropped with rsp_err=1.
REQ-021 Out-of-range reads SHALL return rsp_rdata=0 with rsp_err=1.
REQ-022 RESP: rsp_valid, rsp_rdata and rsp_err SHALL hold stable until a cycle with rsp_ready=1, then the FSM returns to IDLE; req_ready=0 throughout RESP.
REQ-023 Only one outstanding request; the minimum request spacing is LATENCY+1 cycles when rsp_ready is tied high.
REQ-024 req_* inputs SHALL be ignored outside IDLE.
REQ-025 Storage SHALL be zero at time 0 and SHALL NOT be cleared by reset.

Reset
REQ-026 reset=1 SHALL force state IDLE, counter 0, req_ready=1 after the edge, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-027 Reset during WAIT SHALL discard the pending request; an uncommitted write SHALL NOT reach storage.
REQ-028 Reset during RESP SHALL drop the response; a write already committed SHALL remain in storage.

Configuration
REQ-029 With macro MEM_RESPONDER_STATS_EN defined, SHALL add outputs stat_reads and stat_writes (32 bits each), counting completed in-range reads and writes, saturating at all-ones, cleared by reset.
REQ-030 Without MEM_RESPONDER_STATS_EN, those ports and counters SHALL be absent and all other behaviour is identical.

Structure
REQ-031 Shared package mem_pkg SHALL hold the state enum (IDLE/WAIT/RESP) and the default DATAWIDTH, ADDRWIDTH and DEPTH constants.
REQ-032 Storage SHALL be a sub-module mem_array: single-port, synchronous write, combinational read, DEPTH x DATAWIDTH; the FSM and handshake live in mem_responder.

Verification
REQ-033 Reset, then write addr 0x00010 data 0xDEADBEEF with LATENCY=4 -> rsp_valid 4 cycles after acceptance, rsp_err=0; a following read of 0x00010 -> rsp_rdata=0xDEADBEEF.
REQ-034 Read of a never-written addr 0x00123 -> rsp_rdata=0x00000000, rsp_err=0.
REQ-035 DEPTH=1024, write then read addr 0x00400 -> rsp_err=1 and rsp_rdata=0; a read of 0x00000 is unchanged.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0, new req_valid ignored; release -> IDLE the next cycle.
REQ-037 Assert reset 2 cycles after accepting a write to 0x00020 (LATENCY=4) -> after reset, a read of 0x00020 returns the prior value.
REQ-038 With MEM_RESPONDER_STATS_EN defined: 3 writes + 2 reads in range + 1 out-of-range -> stat_writes=3, stat_reads=2.
